// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg -- fetch-stage program counter for the MIPS core.
//
// Holds the address of the instruction being fetched and picks the next PC
// every rising edge of clk. Redirect sources, highest priority first:
//   exception vector, ERET (epc), branch, J/JAL immediate, JR/JALR register,
//   and sequential pc+4 when nothing redirects.
//
// Ports
//   clk            in   1   system clock, rising-edge
//   rst            in   1   synchronous active-high reset -> RESET_VECTOR
//   stall          in   1   hold pc (blocks every redirect)
//   branchImmEx    in   32  sign-extended branch offset, in words
//   jumpImm        in   26  J/JAL instruction index
//   jumpReg        in   32  JR/JALR target
//   epc            in   32  ERET return address
//   takeException  in   1   redirect to EXC_VECTOR
//   takeEret       in   1   redirect to epc
//   takeBranch     in   1   redirect to pc4 + (branchImmEx << 2)
//   takeJumpImm    in   1   redirect to {pc4[31:28], jumpImm, 2'b00}
//   takeJumpReg    in   1   redirect to jumpReg
//   pc             out  32  current PC (registered)
//   pc4            out  32  pc + 4 (combinational)
// ---------------------------------------------------------------------------
module pc_reg #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] branchImmEx,
  input  logic [25:0] jumpImm,
  input  logic [31:0] jumpReg,
  input  logic [31:0] epc,
  input  logic        takeException,
  input  logic        takeEret,
  input  logic        takeBranch,
  input  logic        takeJumpImm,
  input  logic        takeJumpReg,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  logic [31:0] branchTarget;
  logic [31:0] jumpImmTarget;
  logic [31:0] nextPc;

  // All arithmetic wraps modulo 2^32; the shift drops the offset's top two bits.
  assign pc4           = pc + 32'd4;
  assign branchTarget  = pc4 + (branchImmEx << 2);
  // Region bits come from the delay-slot address, not the jump itself.
  assign jumpImmTarget = {pc4[31:28], jumpImm, 2'b00};

  always_comb begin
    nextPc = pc4;
    if (takeException)    nextPc = EXC_VECTOR;
    else if (takeEret)    nextPc = epc;
    else if (takeBranch)  nextPc = branchTarget;
    else if (takeJumpImm) nextPc = jumpImmTarget;
    else if (takeJumpReg) nextPc = jumpReg;
  end

  // Reset dominates everything; stall then freezes pc even against exceptions.
  always_ff @(posedge clk) begin
    if (rst)         pc <= RESET_VECTOR;
    else if (!stall) pc <= nextPc;
  end

endmodule

// File: tb/tb_pc_reg.sv
// ---------------------------------------------------------------------------
// tb_pc_reg -- self-checking bench for pc_reg. Each driven cycle pushes the
// expected pc onto a scoreboard queue; after the edge the entry is popped
// and compared against the registered pc (and pc4).
// ---------------------------------------------------------------------------
module tb_pc_reg;

  localparam logic [31:0] RST_VEC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] branchImmEx;
  logic [25:0] jumpImm;
  logic [31:0] jumpReg;
  logic [31:0] epc;
  logic        takeException;
  logic        takeEret;
  logic        takeBranch;
  logic        takeJumpImm;
  logic        takeJumpReg;
  logic [31:0] pc;
  logic [31:0] pc4;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelPc;
  logic [31:0] expQ[$];

  pc_reg dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branchImmEx  (branchImmEx),
    .jumpImm      (jumpImm),
    .jumpReg      (jumpReg),
    .epc          (epc),
    .takeException(takeException),
    .takeEret     (takeEret),
    .takeBranch   (takeBranch),
    .takeJumpImm  (takeJumpImm),
    .takeJumpReg  (takeJumpReg),
    .pc           (pc),
    .pc4          (pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference next-pc, written as a case over the priority-encoded selector.
  function automatic logic [31:0] modelNext(input logic [31:0] cur);
    logic [31:0] seq;
    logic [31:0] off;
    seq = cur + 32'd4;
    off = {branchImmEx[29:0], 2'b00};
    if (rst) return RST_VEC;
    if (stall) return cur;
    casez ({takeException, takeEret, takeBranch, takeJumpImm, takeJumpReg})
      5'b1????: return EXC_VEC;
      5'b01???: return epc;
      5'b001??: return seq + off;
      5'b0001?: return {seq[31:28], jumpImm, 2'b00};
      5'b00001: return jumpReg;
      default:  return seq;
    endcase
  endfunction

  task automatic clearTakes();
    rst = 1'b0; stall = 1'b0;
    takeException = 1'b0; takeEret = 1'b0; takeBranch = 1'b0;
    takeJumpImm = 1'b0; takeJumpReg = 1'b0;
  endtask

  // Drive the current inputs for one edge and score the result.
  task automatic step(input string tag);
    logic [31:0] e;
    expQ.push_back(modelNext(modelPc));
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    modelPc = e;
    chk(tag, pc, e);
    chk({tag, "_pc4"}, pc4, e + 32'd4);
  endtask

  initial begin
    modelPc = 32'h0;
    branchImmEx = '0; jumpImm = '0; jumpReg = '0; epc = '0;
    clearTakes();
    @(negedge clk);

    // 1: reset then sequential
    rst = 1'b1; step("t1_rst");
    chk("t1_rst_const", pc, RST_VEC);
    chk("t1_rst_pc4_const", pc4, 32'hBFC0_0004);
    clearTakes(); step("t1_seq");
    chk("t1_seq_const", pc, 32'hBFC0_0004);

    // 2: exception, then ERET beats branch
    takeException = 1'b1; step("t2_exc");
    chk("t2_exc_const", pc, EXC_VEC);
    clearTakes(); takeEret = 1'b1; takeBranch = 1'b1;
    epc = 32'h1111_1110; branchImmEx = 32'h0000_0010; step("t2_eret");
    chk("t2_eret_const", pc, 32'h1111_1110);

    // 3: forward branch, then backward -1 word from 1000_0000
    clearTakes(); takeBranch = 1'b1; branchImmEx = 32'h0000_1234; step("t3_br");
    chk("t3_br_const", pc, 32'h1111_59E4);

    // 4: jump immediate, jump register, sequential
    clearTakes(); takeJumpImm = 1'b1; jumpImm = 26'h123_4567; step("t4_jimm");
    chk("t4_jimm_const", pc, 32'h148D_159C);
    clearTakes(); takeJumpReg = 1'b1; jumpReg = 32'h2222_2220; step("t4_jreg");
    chk("t4_jreg_const", pc, 32'h2222_2220);
    clearTakes(); step("t4_seq");
    chk("t4_seq_const", pc, 32'h2222_2224);

    clearTakes(); takeJumpReg = 1'b1; jumpReg = 32'h1000_0000; step("t3_set");
    clearTakes(); takeBranch = 1'b1; branchImmEx = 32'hFFFF_FFFF; step("t3_back");
    chk("t3_back_const", pc, 32'h1000_0000);

    // branch offset whose top bits are discarded by the shift
    clearTakes(); takeBranch = 1'b1; branchImmEx = 32'h4000_0001; step("br_trunc");
    chk("br_trunc_const", pc, 32'h1000_0008);

    // 5: stall blocks exception for 3 edges, then release
    clearTakes(); stall = 1'b1; takeException = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("t5_stall");
      chk("t5_stall_const", pc, 32'h1000_0008);
    end
    stall = 1'b0; step("t5_rel");
    chk("t5_rel_const", pc, EXC_VEC);

    // 6: wrap at top of address space, misaligned jumpReg, reset under stall
    clearTakes(); takeJumpReg = 1'b1; jumpReg = 32'hFFFF_FFFC; step("t6_set");
    chk("t6_pc4_wrap", pc4, 32'h0000_0000);
    clearTakes(); step("t6_wrap");
    chk("t6_wrap_const", pc, 32'h0000_0000);
    clearTakes(); takeJumpReg = 1'b1; jumpReg = 32'h0000_0003; step("misalign");
    chk("misalign_const", pc, 32'h0000_0003);
    clearTakes(); rst = 1'b1; stall = 1'b1; takeException = 1'b1; step("t6_rst_stall");
    chk("t6_rst_stall_const", pc, RST_VEC);

    // Randomised mix of all controls against the model
    clearTakes();
    for (int i = 0; i < 300; i++) begin
      rst           = ($urandom_range(0, 31) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      takeException = ($urandom_range(0, 9) == 0);
      takeEret      = ($urandom_range(0, 7) == 0);
      takeBranch    = ($urandom_range(0, 3) == 0);
      takeJumpImm   = ($urandom_range(0, 3) == 0);
      takeJumpReg   = ($urandom_range(0, 3) == 0);
      branchImmEx   = $urandom;
      jumpImm       = 26'($urandom);
      jumpReg       = $urandom;
      epc           = $urandom;
      step("rand");
    end

    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
